// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector: synchroniser, glitch filter, mode-qualified sticky flags,
// saturating edge counters and a combined interrupt.
module multi_edge_detect #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 3,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [N_CH-1:0]       sig_in,
    input  logic [2*N_CH-1:0]     mode,
    input  logic [N_CH-1:0]       clear,
    output logic [N_CH-1:0]       rise_pulse,
    output logic [N_CH-1:0]       fall_pulse,
    output logic [N_CH-1:0]       event_flag,
    output logic [N_CH*CNT_W-1:0] edge_count,
    output logic                  irq
);

    localparam int unsigned       FC_W    = $clog2(FILT_CYCLES + 1);
    localparam logic [FC_W-1:0]   FC_LAST = FC_W'(FILT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] r_sync [N_CH];
    logic [FC_W-1:0]        r_fc   [N_CH];
    logic [CNT_W-1:0]       r_cnt  [N_CH];
    logic [N_CH-1:0]        r_filt;
    logic [N_CH-1:0]        r_rise;
    logic [N_CH-1:0]        r_fall;
    logic [N_CH-1:0]        r_flag;
    logic                   r_irq;

    logic [N_CH-1:0]        w_sync;
    logic [N_CH-1:0]        w_qual;

    // Qualification uses the registered pulse against the mode value of this cycle.
    always_comb begin
        w_sync = '0;
        w_qual = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            w_sync[c] = r_sync[c][SYNC_STAGES-1];
            w_qual[c] = (r_rise[c] & mode[2*c]) | (r_fall[c] & mode[2*c+1]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < int'(N_CH); c++) begin
                r_sync[c] <= '0;
                r_fc[c]   <= '0;
                r_cnt[c]  <= '0;
            end
            r_filt <= '0;
            r_rise <= '0;
            r_fall <= '0;
            r_flag <= '0;
            r_irq  <= 1'b0;
        end else begin
            for (int c = 0; c < int'(N_CH); c++) begin
                r_sync[c] <= {r_sync[c][SYNC_STAGES-2:0], sig_in[c]};
                r_rise[c] <= 1'b0;
                r_fall[c] <= 1'b0;

                if (w_sync[c] == r_filt[c]) begin
                    r_fc[c] <= '0;
                end else if (r_fc[c] == FC_LAST) begin
                    r_filt[c] <= w_sync[c];
                    r_fc[c]   <= '0;
                    r_rise[c] <= w_sync[c];
                    r_fall[c] <= ~w_sync[c];
                end else begin
                    r_fc[c] <= r_fc[c] + 1'b1;
                end

                // An edge coinciding with clear wins and restarts the count at one.
                if (w_qual[c]) begin
                    r_flag[c] <= 1'b1;
                    if (clear[c]) begin
                        r_cnt[c] <= CNT_W'(1);
                    end else if (r_cnt[c] != CNT_MAX) begin
                        r_cnt[c] <= r_cnt[c] + 1'b1;
                    end
                end else if (clear[c]) begin
                    r_flag[c] <= 1'b0;
                    r_cnt[c]  <= '0;
                end
            end
            r_irq <= |r_flag;
        end
    end

    always_comb begin
        edge_count = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            edge_count[c*CNT_W +: CNT_W] = r_cnt[c];
        end
    end

    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign event_flag = r_flag;
    assign irq        = r_irq;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Bench for multi_edge_detect: directed scenarios plus random traffic against a
// window-based reference model of the synchronise/filter/count behaviour.
module tb_multi_edge_detect;

    localparam int unsigned N_CH        = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned FILT_CYCLES = 3;
    localparam int unsigned CNT_W       = 8;
    localparam int          CNT_MAX     = (1 << CNT_W) - 1;

    logic                  clock = 1'b0;
    logic                  reset_n;
    logic [N_CH-1:0]       sig_in;
    logic [2*N_CH-1:0]     mode;
    logic [N_CH-1:0]       clear;
    logic [N_CH-1:0]       rise_pulse;
    logic [N_CH-1:0]       fall_pulse;
    logic [N_CH-1:0]       event_flag;
    logic [N_CH*CNT_W-1:0] edge_count;
    logic                  irq;

    always #5 clock = ~clock;

    multi_edge_detect #(
        .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset_n(reset_n), .sig_in(sig_in), .mode(mode), .clear(clear),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .event_flag(event_flag),
        .edge_count(edge_count), .irq(irq)
    );

    // Reference model: raw input log since reset; a level is accepted once the last
    // FILT_CYCLES synchronised samples all differ from the accepted level.
    logic [N_CH-1:0] raw_log[$];
    logic [N_CH-1:0] m_f, m_rise, m_fall, m_flag;
    logic            m_irq;
    int              m_cnt[N_CH];
    int              checks = 0;
    int              errors = 0;
    int              rises, falls;
    bit              seen;

    function automatic logic s_before(int n, int c);
        int idx;
        idx = n - int'(SYNC_STAGES) - 1;
        if (idx < 0) return 1'b0;
        return raw_log[idx][c];
    endfunction

    task automatic model_reset();
        raw_log.delete();
        m_f = '0; m_rise = '0; m_fall = '0; m_flag = '0; m_irq = 1'b0;
        for (int c = 0; c < int'(N_CH); c++) m_cnt[c] = 0;
    endtask

    task automatic model_edge();
        int  n;
        bit  acc, q;
        m_irq = |m_flag;
        raw_log.push_back(sig_in);
        n = raw_log.size();
        for (int c = 0; c < int'(N_CH); c++) begin
            q = (m_rise[c] && mode[2*c]) || (m_fall[c] && mode[2*c+1]);
            if (q) begin
                m_flag[c] = 1'b1;
                m_cnt[c]  = clear[c] ? 1 : ((m_cnt[c] < CNT_MAX) ? m_cnt[c] + 1 : CNT_MAX);
            end else if (clear[c]) begin
                m_flag[c] = 1'b0;
                m_cnt[c]  = 0;
            end
            acc = 1'b1;
            for (int j = 0; j < int'(FILT_CYCLES); j++) begin
                if (n - j < 1) acc = 1'b0;
                else if (s_before(n - j, c) == m_f[c]) acc = 1'b0;
            end
            m_rise[c] = acc && !m_f[c];
            m_fall[c] = acc && m_f[c];
            if (acc) m_f[c] = ~m_f[c];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("rise", 32'(rise_pulse), 32'(m_rise));
        chk("fall", 32'(fall_pulse), 32'(m_fall));
        chk("flag", 32'(event_flag), 32'(m_flag));
        chk("irq", 32'(irq), 32'(m_irq));
        chk("excl", 32'(rise_pulse & fall_pulse), 32'd0);
        for (int c = 0; c < int'(N_CH); c++)
            chk($sformatf("cnt%0d", c), 32'(edge_count[c*CNT_W +: CNT_W]), m_cnt[c]);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        reset_n = 1'b0; sig_in = '0; mode = '0; clear = '0;
        model_reset();
        #2;
        chk("rst_outs", 32'({rise_pulse, fall_pulse, event_flag, irq}), 32'd0);
        chk("rst_cnt", edge_count, 32'd0);
        reset_n = 1'b1;

        // Latency and counting on ch0
        mode[1:0] = 2'b11;
        sig_in[0] = 1'b1;
        repeat (4) step();
        chk("lat_early", 32'(rise_pulse[0]), 32'd0);
        step();
        chk("lat_rise", 32'(rise_pulse[0]), 32'd1);
        chk("lat_irq_pre", 32'(irq), 32'd0);
        step();
        chk("lat_cnt1", 32'(edge_count[7:0]), 32'd1);
        chk("lat_flag", 32'(event_flag[0]), 32'd1);
        step();
        chk("lat_irq", 32'(irq), 32'd1);
        sig_in[0] = 1'b0;
        repeat (5) step();
        chk("lat_fall", 32'(fall_pulse[0]), 32'd1);
        step();
        chk("lat_cnt2", 32'(edge_count[7:0]), 32'd2);

        // Glitch rejection on ch1
        mode[3:2] = 2'b11;
        sig_in[1] = 1'b1;
        repeat (2) step();
        sig_in[1] = 1'b0;
        repeat (8) step();
        chk("glitch_cnt", 32'(edge_count[15:8]), 32'd0);
        sig_in[1] = 1'b1;
        rises = 0;
        repeat (3) begin step(); rises += int'(rise_pulse[1]); end
        sig_in[1] = 1'b0;
        repeat (10) begin step(); rises += int'(rise_pulse[1]); end
        chk("glitch_accept", rises, 32'd1);

        // Mode gating on ch2
        for (int m = 0; m < 3; m++) begin
            mode[5:4] = (m == 0) ? 2'b01 : (m == 1) ? 2'b10 : 2'b00;
            rises = 0; falls = 0;
            repeat (3) begin
                sig_in[2] = 1'b1;
                repeat (4) begin step(); rises += int'(rise_pulse[2]); falls += int'(fall_pulse[2]); end
                sig_in[2] = 1'b0;
                repeat (4) begin step(); rises += int'(rise_pulse[2]); falls += int'(fall_pulse[2]); end
            end
            repeat (6) begin step(); rises += int'(rise_pulse[2]); falls += int'(fall_pulse[2]); end
            chk($sformatf("mode%0d_rise", m), rises, 32'd3);
            chk($sformatf("mode%0d_fall", m), falls, 32'd3);
            chk($sformatf("mode%0d_cnt", m), 32'(edge_count[23:16]), (m == 0) ? 32'd3 : 32'd6);
        end

        // Saturation and clear on ch3
        mode[7:6] = 2'b01;
        repeat (260) begin
            sig_in[3] = 1'b1; repeat (4) step();
            sig_in[3] = 1'b0; repeat (4) step();
        end
        repeat (4) step();
        chk("sat_cnt", 32'(edge_count[31:24]), 32'd255);
        clear[3] = 1'b1; step(); clear[3] = 1'b0;
        chk("clr_cnt", 32'(edge_count[31:24]), 32'd0);
        chk("clr_flag", 32'(event_flag[3]), 32'd0);
        sig_in[3] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            seen = rise_pulse[3];
        end
        chk("coinc_seen", 32'(seen), 32'd1);
        clear[3] = 1'b1; step(); clear[3] = 1'b0;
        chk("coinc_flag", 32'(event_flag[3]), 32'd1);
        chk("coinc_cnt", 32'(edge_count[31:24]), 32'd1);

        // Concurrency
        repeat (8) step();
        mode = '1;
        clear = '1; step(); clear = '0;
        repeat (2) step();
        chk("conc_irq0", 32'(irq), 32'd0);
        sig_in = ~sig_in;
        repeat (5) step();
        chk("conc_pulses", 32'(rise_pulse | fall_pulse), 32'hF);
        chk("conc_irq_pre", 32'(irq), 32'd0);
        step();
        chk("conc_flags", 32'(event_flag), 32'hF);
        chk("conc_cnts", edge_count, 32'h01010101);
        step();
        chk("conc_irq", 32'(irq), 32'd1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < int'(N_CH); c++) begin
                if ($urandom_range(0, 3) == 0) sig_in[c] = ~sig_in[c];
                clear[c] = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 31) == 0) mode[2*c +: 2] = 2'($urandom_range(0, 3));
            end
            step();
        end
        clear = '0;

        // Asynchronous reset mid-operation, then release with ch0 held high
        mode[1:0] = 2'b11;
        step();
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_outs", 32'({rise_pulse, fall_pulse, event_flag, irq}), 32'd0);
        chk("arst_cnt", edge_count, 32'd0);
        model_reset();
        @(posedge clock);
        #1;
        sig_in = '0;
        sig_in[0] = 1'b1;
        reset_n = 1'b1;
        repeat (4) step();
        chk("arst_early", 32'(rise_pulse[0]), 32'd0);
        step();
        chk("arst_rise", 32'(rise_pulse[0]), 32'd1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
